// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: register/data widths, ALU operand-B select encodings, ID/EX record.
// No logic of its own; purely declarations plus one small helper.
// Imported by id_ex_stage and hazard_detect.
package mips_pkg;

  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int ALUCTR_W = 4;
  localparam int CNT_W    = 16;

  // Operand-B source; FWD_* values are only ever produced by the forwarding unit.
  typedef enum logic [1:0] {
    ALUSRC_BUSB    = 2'd0,
    ALUSRC_IMM     = 2'd1,
    ALUSRC_FWD_MEM = 2'd2,
    ALUSRC_FWD_WR  = 2'd3
  } alusrc_e;

  // Contents of the ID/EX pipeline register; all-zero is a bubble.
  typedef struct packed {
    logic                valid;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rw;
    logic [DATA_W-1:0]   bus_a;
    logic [DATA_W-1:0]   bus_b;
    logic [DATA_W-1:0]   imm;
    logic                reg_wr;
    logic                mem_read;
    logic                mem_wr;
    alusrc_e             alu_src_b;
    logic [ALUCTR_W-1:0] alu_ctr;
  } id_ex_t;

  // Decode only selects BusB or Imm; anything else from ID collapses to BusB
  // so the stage never emits a forwarding encoding on its own.
  function automatic alusrc_e sanitize_alusrc(input logic [1:0] sel);
    return (sel == ALUSRC_IMM) ? ALUSRC_IMM : ALUSRC_BUSB;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detect: EX holds a valid load whose nonzero Rt is read by the ID instruction.
// Latency: purely combinational.
// Backpressure: none; the result is consumed by id_ex_stage to stall/bubble.
module hazard_detect
  import mips_pkg::*;
(
  input  logic             valid_ex,
  input  logic             mem_read_ex,
  input  logic [REG_W-1:0] rt_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  output logic             hazard
);

  // Register 0 is hard-wired zero, so a load into it can never create a dependency.
  always_comb begin
    hazard = valid_ex & mem_read_ex & (rt_ex != '0) &
             ((rt_ex == rs_id) | (rt_ex == rt_id));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall (macro LOAD_USE_HAZARD_EN enables hazard + stall counter).
// Latency: one cycle from ID inputs to EX outputs; Stall is combinational.
// Backpressure: on load-use, Stall holds PC/IF-ID for one cycle while a bubble enters EX; Flush wins.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_W-1:0]    Rs_Id,
  input  logic [REG_W-1:0]    Rt_Id,
  input  logic [REG_W-1:0]    Rd_Id,
  input  logic [DATA_W-1:0]   BusA_Id,
  input  logic [DATA_W-1:0]   BusB_Id,
  input  logic [DATA_W-1:0]   Imm_Id,
  input  logic                RegWr_Id,
  input  logic                RegDst_Id,
  input  logic                MemRead_Id,
  input  logic                MemWr_Id,
  input  logic [1:0]          ALUSrcB_Id,
  input  logic [ALUCTR_W-1:0] ALUCtr_Id,
  input  logic                Flush,
  output logic [REG_W-1:0]    Rs_Ex,
  output logic [REG_W-1:0]    Rt_Ex,
  output logic [REG_W-1:0]    Rw_Ex,
  output logic [DATA_W-1:0]   BusA_Ex,
  output logic [DATA_W-1:0]   BusB_Ex,
  output logic [DATA_W-1:0]   Imm_Ex,
  output logic                RegWr_Ex,
  output logic                MemRead_Ex,
  output logic                MemWr_Ex,
  output logic                Valid_Ex,
  output logic [1:0]          ALUSrcB_Ex,
  output logic [ALUCTR_W-1:0] ALUCtr_Ex,
  output logic                Stall,
  output logic [CNT_W-1:0]    Stall_Cnt
);

  id_ex_t id_rec;
  id_ex_t ex_q;
  logic   hazard;

  // Assemble the ID instruction as it would appear in EX, resolving the destination register.
  always_comb begin
    id_rec           = '0;
    id_rec.valid     = 1'b1;
    id_rec.rs        = Rs_Id;
    id_rec.rt        = Rt_Id;
    id_rec.rw        = RegDst_Id ? Rd_Id : Rt_Id;
    id_rec.bus_a     = BusA_Id;
    id_rec.bus_b     = BusB_Id;
    id_rec.imm       = Imm_Id;
    id_rec.reg_wr    = RegWr_Id;
    id_rec.mem_read  = MemRead_Id;
    id_rec.mem_wr    = MemWr_Id;
    id_rec.alu_src_b = sanitize_alusrc(ALUSrcB_Id);
    id_rec.alu_ctr   = ALUCtr_Id;
  end

  // Pipeline register: reset, then bubble on flush/hazard, else take the ID instruction.
  // The bubble clears mem_read, which is what limits a load-use stall to one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (Flush | hazard) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_rec;
    end
  end

  assign Rs_Ex      = ex_q.rs;
  assign Rt_Ex      = ex_q.rt;
  assign Rw_Ex      = ex_q.rw;
  assign BusA_Ex    = ex_q.bus_a;
  assign BusB_Ex    = ex_q.bus_b;
  assign Imm_Ex     = ex_q.imm;
  assign RegWr_Ex   = ex_q.reg_wr;
  assign MemRead_Ex = ex_q.mem_read;
  assign MemWr_Ex   = ex_q.mem_wr;
  assign Valid_Ex   = ex_q.valid;
  assign ALUSrcB_Ex = ex_q.alu_src_b;
  assign ALUCtr_Ex  = ex_q.alu_ctr;

  // A flushed ID instruction is dead anyway, so holding the front end would only waste a cycle.
  assign Stall = hazard & ~Flush;

`ifdef LOAD_USE_HAZARD_EN
  logic [CNT_W-1:0] stall_cnt_q;

  hazard_detect u_hazard_detect (
    .valid_ex    (ex_q.valid),
    .mem_read_ex (ex_q.mem_read),
    .rt_ex       (ex_q.rt),
    .rs_id       (Rs_Id),
    .rt_id       (Rt_Id),
    .hazard      (hazard)
  );

  // Count stall cycles, saturating rather than wrapping so the figure stays a lower bound.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (Stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign Stall_Cnt = stall_cnt_q;
`else
  // Hazard detection disabled: bubbles come only from Flush and the counter stays at zero.
  assign hazard    = 1'b0;
  assign Stall_Cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases then randomized traffic vs. a behavioural model.
// Expectations follow LOAD_USE_HAZARD_EN the same way the design build does.
// Inputs driven on the falling edge; outputs sampled 1ns after edges.
module tb_id_ex_stage;

`ifdef LOAD_USE_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_id, rt_id, rd_id;
  logic [31:0] bus_a_id, bus_b_id, imm_id;
  logic        regwr_id, regdst_id, memrd_id, memwr_id, flush;
  logic [1:0]  src_id;
  logic [3:0]  ctr_id;

  logic [4:0]  Rs_Ex, Rt_Ex, Rw_Ex;
  logic [31:0] BusA_Ex, BusB_Ex, Imm_Ex;
  logic        RegWr_Ex, MemRead_Ex, MemWr_Ex, Valid_Ex, Stall;
  logic [1:0]  ALUSrcB_Ex;
  logic [3:0]  ALUCtr_Ex;
  logic [15:0] Stall_Cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: what EX should hold, and the stall count.
  logic [4:0]  m_rs, m_rt, m_rw;
  logic [31:0] m_a, m_b, m_imm;
  logic        m_regwr, m_memrd, m_memwr, m_valid;
  logic [1:0]  m_src;
  logic [3:0]  m_ctr;
  logic [15:0] m_cnt;
  bit          m_init = 1'b0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .Rs_Id(rs_id), .Rt_Id(rt_id), .Rd_Id(rd_id),
    .BusA_Id(bus_a_id), .BusB_Id(bus_b_id), .Imm_Id(imm_id),
    .RegWr_Id(regwr_id), .RegDst_Id(regdst_id), .MemRead_Id(memrd_id), .MemWr_Id(memwr_id),
    .ALUSrcB_Id(src_id), .ALUCtr_Id(ctr_id), .Flush(flush),
    .Rs_Ex(Rs_Ex), .Rt_Ex(Rt_Ex), .Rw_Ex(Rw_Ex),
    .BusA_Ex(BusA_Ex), .BusB_Ex(BusB_Ex), .Imm_Ex(Imm_Ex),
    .RegWr_Ex(RegWr_Ex), .MemRead_Ex(MemRead_Ex), .MemWr_Ex(MemWr_Ex), .Valid_Ex(Valid_Ex),
    .ALUSrcB_Ex(ALUSrcB_Ex), .ALUCtr_Ex(ALUCtr_Ex),
    .Stall(Stall), .Stall_Cnt(Stall_Cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    {m_rs, m_rt, m_rw} = '0;
    {m_a, m_b, m_imm} = '0;
    {m_regwr, m_memrd, m_memwr, m_valid} = '0;
    m_src = '0;
    m_ctr = '0;
  endtask

  task automatic check_outs();
    chk("rs_ex", Rs_Ex, m_rs);
    chk("rt_ex", Rt_Ex, m_rt);
    chk("rw_ex", Rw_Ex, m_rw);
    chk("busa_ex", BusA_Ex, m_a);
    chk("busb_ex", BusB_Ex, m_b);
    chk("imm_ex", Imm_Ex, m_imm);
    chk("regwr_ex", RegWr_Ex, m_regwr);
    chk("memrd_ex", MemRead_Ex, m_memrd);
    chk("memwr_ex", MemWr_Ex, m_memwr);
    chk("valid_ex", Valid_Ex, m_valid);
    chk("alusrcb_ex", ALUSrcB_Ex, m_src);
    chk("aluctr_ex", ALUCtr_Ex, m_ctr);
    chk("stall_cnt", Stall_Cnt, m_cnt);
  endtask

  // One clock: check Stall on current inputs, advance model at the edge, check registered outputs.
  task automatic step();
    logic hz, st;
    hz = HZ && m_valid && m_memrd && (m_rt != 5'd0) && ((m_rt == rs_id) || (m_rt == rt_id));
    st = hz && !flush;
    #1;
    if (m_init) chk("stall", Stall, st);
    @(posedge clk);
    if (rst) begin
      model_clear();
      m_cnt  = 16'h0;
      m_init = 1'b1;
    end else begin
      if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (flush || hz) model_clear();
      else begin
        m_rs = rs_id; m_rt = rt_id; m_rw = regdst_id ? rd_id : rt_id;
        m_a = bus_a_id; m_b = bus_b_id; m_imm = imm_id;
        m_regwr = regwr_id; m_memrd = memrd_id; m_memwr = memwr_id; m_valid = 1'b1;
        m_src = (src_id == 2'd1) ? 2'd1 : 2'd0;
        m_ctr = ctr_id;
      end
    end
    #1;
    if (m_init) check_outs();
    @(negedge clk);
  endtask

  task automatic set_lw(input logic [4:0] rt);
    rs_id = 5'd29; rt_id = rt; rd_id = 5'd0;
    bus_a_id = 32'h1000_0000; bus_b_id = 32'h0; imm_id = 32'h10;
    regwr_id = 1'b1; regdst_id = 1'b0; memrd_id = 1'b1; memwr_id = 1'b0;
    src_id = 2'd1; ctr_id = 4'h2;
  endtask

  task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    rs_id = rs; rt_id = rt; rd_id = rd;
    bus_a_id = 32'h0000_1111; bus_b_id = 32'h0000_2222; imm_id = 32'h0;
    regwr_id = 1'b1; regdst_id = 1'b1; memrd_id = 1'b0; memwr_id = 1'b0;
    src_id = 2'd0; ctr_id = 4'h2;
  endtask

  initial begin
    logic [15:0] cnt_save;
    flush = 1'b0;
    @(negedge clk);

    // Reset with every ID input nonzero.
    rst = 1'b1;
    rs_id = 5'd5; rt_id = 5'd6; rd_id = 5'd7;
    bus_a_id = 32'hDEAD_BEEF; bus_b_id = 32'h1234_5678; imm_id = 32'hFFFF_0001;
    regwr_id = 1'b1; regdst_id = 1'b1; memrd_id = 1'b1; memwr_id = 1'b1;
    src_id = 2'd1; ctr_id = 4'hF;
    step();
    chk("rst_valid", Valid_Ex, 0);
    chk("rst_busa", BusA_Ex, 0);
    chk("rst_cnt", Stall_Cnt, 0);
    rst = 1'b0;

    // Pass-through.
    set_add(5'd1, 5'd2, 5'd3);
    bus_a_id = 32'hA5A5_0001;
    step();
    chk("pt_rw", Rw_Ex, 3);
    chk("pt_busa", BusA_Ex, 32'hA5A5_0001);
    chk("pt_valid", Valid_Ex, 1);
    #1 chk("pt_stall", Stall, 0);

    // Load-use: one stall cycle, bubble, then the add enters EX.
    set_lw(5'd8);
    step();
    set_add(5'd8, 5'd10, 5'd11);
    #1 chk("lu_stall", Stall, HZ);
    step();
    chk("lu_bubble_valid", Valid_Ex, !HZ);
    chk("lu_bubble_memrd", MemRead_Ex, 0);
    #1 chk("lu_stall_once", Stall, 0);
    step();
    chk("lu_add_valid", Valid_Ex, 1);
    chk("lu_add_rw", Rw_Ex, 11);
    chk("lu_cnt", Stall_Cnt, HZ ? 1 : 0);

    // Load to register 0 never stalls.
    set_lw(5'd0);
    step();
    set_add(5'd0, 5'd4, 5'd12);
    #1 chk("zero_stall", Stall, 0);
    step();
    chk("zero_valid", Valid_Ex, 1);

    // Flush coinciding with a hazard: bubble, no stall, counter unchanged.
    set_lw(5'd8);
    step();
    cnt_save = Stall_Cnt;
    set_add(5'd8, 5'd10, 5'd11);
    flush = 1'b1;
    #1 chk("fh_stall", Stall, 0);
    step();
    flush = 1'b0;
    chk("fh_valid", Valid_Ex, 0);
    chk("fh_memrd", MemRead_Ex, 0);
    chk("fh_cnt", Stall_Cnt, cnt_save);

    // Reset during a stall drops everything; no leftover stall.
    set_lw(5'd9);
    step();
    set_add(5'd9, 5'd1, 5'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 chk("rs_stall", Stall, 0);
    step();
    chk("rs_valid", Valid_Ex, 1);
    chk("rs_cnt", Stall_Cnt, 0);

    // Saturation from a preloaded count.
`ifdef LOAD_USE_HAZARD_EN
    force dut.stall_cnt_q = 16'hFFFE;
    #1 release dut.stall_cnt_q;
    m_cnt = 16'hFFFE;
`endif
    for (int i = 0; i < 3; i++) begin
      set_lw(5'd7);
      step();
      set_add(5'd3, 5'd7, 5'd4);
      step();
    end
    chk("sat_cnt", Stall_Cnt, HZ ? 32'hFFFF : 32'h0);

    // Randomized traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      rs_id     = 5'($urandom_range(0, 3));
      rt_id     = 5'($urandom_range(0, 3));
      rd_id     = 5'($urandom_range(0, 31));
      bus_a_id  = $urandom;
      bus_b_id  = $urandom;
      imm_id    = $urandom;
      regwr_id  = 1'($urandom_range(0, 1));
      regdst_id = 1'($urandom_range(0, 1));
      memrd_id  = ($urandom_range(0, 2) == 0);
      memwr_id  = 1'($urandom_range(0, 1));
      src_id    = 2'($urandom_range(0, 3));
      ctr_id    = 4'($urandom_range(0, 15));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge), rst input 1 (synchronous, active-high).
REQ-002 SHALL have ID-side inputs Rs_Id, Rt_Id, Rd_Id (5 b each): decoded register numbers.
REQ-003 SHALL have ID-side inputs BusA_Id, BusB_Id, Imm_Id (32 b each): register-file read data and extended immediate.
REQ-004 SHALL have ID-side control inputs RegWr_Id, RegDst_Id, MemRead_Id, MemWr_Id (1 b each), ALUSrcB_Id (2 b, only 0=BusB or 1=Imm), ALUCtr_Id (4 b).
REQ-005 SHALL have input Flush (1 b): branch/jump taken, kill the instruction in ID.
REQ-006 SHALL have EX-side outputs Rs_Ex, Rt_Ex, Rw_Ex (5 b each), BusA_Ex, BusB_Ex, Imm_Ex (32 b each), RegWr_Ex, MemRead_Ex, MemWr_Ex, Valid_Ex (1 b each), ALUSrcB_Ex (2 b), ALUCtr_Ex (4 b); Rs_Ex, Rt_Ex and ALUSrcB_Ex feed the forwarding unit.
REQ-007 SHALL have output Stall (1 b, combinational): hold PC and IF/ID this cycle.
REQ-008 SHALL have output Stall_Cnt (16 b): count of stall cycles.

Function
REQ-009 SHALL register all EX-side outputs on the rising edge of clk; capture latency from ID inputs to EX outputs is exactly one cycle.
REQ-010 SHALL capture Rw_Ex as Rd_Id when RegDst_Id=1, else Rt_Id.
REQ-011 SHALL compute Hazard = Valid_Ex & MemRead_Ex & (Rt_Ex!=0) & ((Rt_Ex==Rs_Id) | (Rt_Ex==Rt_Id)).
REQ-012 SHALL drive Stall = Hazard & ~Flush.
REQ-013 SHALL load a bubble, not the ID instruction, when Flush=1 or Hazard=1: every EX-side output becomes 0, Valid_Ex=0.
REQ-014 SHALL otherwise load the ID instruction with Valid_Ex=1.
REQ-015 SHALL make a load-use stall last exactly one cycle: the bubble clears MemRead_Ex, so Hazard is deasserted in the following cycle.
REQ-016 SHALL give Flush priority when Flush and Hazard coincide: bubble loaded, Stall=0.
REQ-017 SHALL never itself produce ALUSrcB_Ex values 2 or 3; those encodings belong to forwarding.
REQ-018 SHALL increment Stall_Cnt by 1 on each rising edge at which Stall=1, saturating at 16'hFFFF with no wrap.

Reset
REQ-019 SHALL, while rst=1 at a rising edge, clear every EX-side output, Valid_Ex and Stall_Cnt to 0; rst overrides Flush and Hazard.
REQ-020 SHALL produce Stall=0 in the first cycle after reset, because Valid_Ex=0.
REQ-021 SHALL drop any instruction in flight when reset is asserted mid-stall, with no leftover stall afterwards.

Configuration
REQ-022 SHALL, with macro LOAD_USE_HAZARD_EN defined, implement REQ-011/012/015/018 as written.
REQ-023 SHALL, with LOAD_USE_HAZARD_EN undefined, tie Hazard to 0: Stall=0, Stall_Cnt constant 0, and bubbles come only from Flush.

Structure
REQ-024 SHALL take the ALUSrcB encodings (0 BusB, 1 Imm, 2 fwd Mem, 3 fwd Wr), ALUCtr width and register-number width from shared package mips_pkg.
REQ-025 SHALL put the Hazard comparison in combinational sub-module hazard_detect; the pipeline register and the counter stay in id_ex_stage.

Verification
REQ-026 Reset: rst=1 with Flush=0 and all ID inputs nonzero -> next edge all outputs 0, Valid_Ex=0, Stall_Cnt=0.
REQ-027 Pass-through: ID has Rs=1, Rt=2, Rd=3, RegDst=1, BusA=32'hA5A5_0001, ALUCtr=4'h2 -> next edge Rw_Ex=3, BusA_Ex=32'hA5A5_0001, Valid_Ex=1, Stall=0.
REQ-028 Load-use: EX holds lw with Rt_Ex=8; ID has Rs_Id=8 -> Stall=1 for exactly 1 cycle, bubble in EX (MemRead_Ex=0), add loaded on next edge, Stall_Cnt=1.
REQ-029 Zero register: lw with Rt_Ex=0 and Rs_Id=0 -> Stall=0, no bubble.
REQ-030 Flush+hazard: load-use as in REQ-028 with Flush=1 in the same cycle -> Stall=0, bubble loaded, Stall_Cnt unchanged.
REQ-031 Saturation: preload Stall_Cnt to 16'hFFFE, apply 3 stall cycles -> Stall_Cnt=16'hFFFF; repeat with LOAD_USE_HAZARD_EN undefined -> Stall=0 and Stall_Cnt=0 throughout.
